// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch port, the loader/data port and the shared
// single-port memory. The arbiter takes the slave view; the environment
// (requesters and memory) takes the master view.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Port 0: instruction fetch, read-only
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_gnt;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_rvalid;

    // Port 1: program loader / data access, read-write
    logic              p1_req;
    logic              p1_we;
    logic              p1_lock;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

    // Shared memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_addr,
        output p0_gnt, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rdata, p1_rvalid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_addr,
        input  p0_gnt, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rdata, p1_rvalid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-port memory (1-cycle registered read) between the fetch
// port (port 0) and the loader/data port (port 1). BOOT lets only port 1 in
// so the loader can fill memory; RUN shares round-robin with a port 1 lock.
module imem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_done,
    output logic                  booting,
    imem_port_arbiter_if.slave    bus
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic              last_p1;
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              p0_pend;
    logic              p1_pend;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;

    // Same-cycle arbitration: BOOT admits port 1 only, RUN is round-robin with lock
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state == BOOT) begin
                grant1 = bus.p1_req;
            end else if (bus.p0_req && bus.p1_req) begin
                if (bus.p1_lock || !last_p1) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = bus.p0_req;
                grant1 = bus.p1_req;
            end
        end
    end

    assign bus.p0_gnt    = grant0;
    assign bus.p1_gnt    = grant1;
    assign bus.mem_re    = grant0 | (grant1 & ~bus.p1_we);
    assign bus.mem_we    = grant1 & bus.p1_we;
    // Address/data pass straight through when granted, otherwise hold the last driven value
    assign bus.mem_addr  = grant0 ? bus.p0_addr :
                           grant1 ? bus.p1_addr : addr_q;
    assign bus.mem_wdata = (grant0 | grant1) ? bus.p1_wdata : wdata_q;

    // Read data is forwarded in the rvalid cycle and held afterwards
    assign bus.p0_rvalid = p0_pend;
    assign bus.p1_rvalid = p1_pend;
    assign bus.p0_rdata  = p0_pend ? bus.mem_rdata : p0_rdata_q;
    assign bus.p1_rdata  = p1_pend ? bus.mem_rdata : p1_rdata_q;

    assign booting = rst | (state == BOOT);

    // Phase FSM, last-grant tracking, bus hold registers and read-return tagging
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            last_p1    <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_pend    <= 1'b0;
            p1_pend    <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            if (state == BOOT && boot_done) begin
                state <= RUN;
            end
            if (grant0) begin
                last_p1 <= 1'b0;
            end else if (grant1) begin
                last_p1 <= 1'b1;
            end
            if (grant0 || grant1) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.p1_wdata;
            end
            p0_pend <= grant0;
            p1_pend <= grant1 & ~bus.p1_we;
            if (p0_pend) begin
                p0_rdata_q <= bus.mem_rdata;
            end
            if (p1_pend) begin
                p1_rdata_q <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small behavioural memory
// (1-cycle registered read) hung off the memory side of the bus.
module tb_imem_port_arbiter;

    logic clk;
    logic rst;
    logic boot_done;
    logic booting;
    int   checks;
    int   errors;

    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_done (boot_done),
        .booting   (booting),
        .bus       (bus)
    );

    logic [31:0] mem [0:31];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write on mem_we, registered read on mem_re
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        int unsigned k;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        boot_done = 1'b1;
        bus.p0_req = 1'b0; bus.p0_addr = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
        bus.p1_addr = '0; bus.p1_wdata = '0;

        // Reset held with boot_done high; requests are masked combinationally
        next();
        next();
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        #1;
        check("rst_p0_gnt", bus.p0_gnt, 1'b0);
        check("rst_p1_gnt", bus.p1_gnt, 1'b0);
        check("rst_mem_re", bus.mem_re, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_booting", booting, 1'b1);

        // Release reset, check reset values and that boot_done was ignored
        next();
        rst = 1'b0; boot_done = 1'b0; bus.p1_req = 1'b0;
        #1;
        check("rv_p0_rvalid", bus.p0_rvalid, 1'b0);
        check("rv_p1_rvalid", bus.p1_rvalid, 1'b0);
        check("rv_p0_rdata", bus.p0_rdata, 32'h0);
        check("rv_p1_rdata", bus.p1_rdata, 32'h0);
        check("rv_mem_addr", bus.mem_addr, 32'h0);
        check("rv_mem_wdata", bus.mem_wdata, 32'h0);
        check("rv_booting", booting, 1'b1);

        // BOOT: fetch requests are never granted
        for (int c = 0; c < 10; c++) begin
            next();
            check("boot_p0_gnt", bus.p0_gnt, 1'b0);
            check("boot_booting", booting, 1'b1);
            check("boot_mem_re", bus.mem_re, 1'b0);
        end

        // BOOT: loader writes 8 words while fetch keeps requesting
        for (int unsigned n = 0; n < 8; n++) begin
            next();
            bus.p1_req = 1'b1; bus.p1_we = 1'b1;
            bus.p1_addr = 4 * n; bus.p1_wdata = 32'hA000_0000 + n;
            #1;
            check("wr_p1_gnt", bus.p1_gnt, 1'b1);
            check("wr_p0_gnt", bus.p0_gnt, 1'b0);
            check("wr_mem_we", bus.mem_we, 1'b1);
            check("wr_mem_re", bus.mem_re, 1'b0);
            check("wr_mem_addr", bus.mem_addr, 4 * n);
            check("wr_mem_wdata", bus.mem_wdata, 32'hA000_0000 + n);
            check("wr_p1_rvalid", bus.p1_rvalid, 1'b0);
        end

        // boot_done held for two cycles
        next();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.p1_we = 1'b0; boot_done = 1'b1;
        #1;
        check("bd_booting0", booting, 1'b1);
        check("bd_p1_rvalid", bus.p1_rvalid, 1'b0);
        check("bd_mem_we", bus.mem_we, 1'b0);
        check("bd_addr_hold", bus.mem_addr, 32'd28);
        check("bd_wdata_hold", bus.mem_wdata, 32'hA000_0007);
        next();
        check("bd_booting1", booting, 1'b0);
        next();
        boot_done = 1'b0;
        #1;
        check("bd_booting2", booting, 1'b0);

        // RUN: both ports read continuously, grants alternate starting with p0
        for (int i = 0; i < 6; i++) begin
            next();
            bus.p0_req = 1'b1; bus.p1_req = 1'b1;
            bus.p0_addr = 4 * ((i + 1) / 2);
            bus.p1_addr = 28 - 4 * (i / 2);
            #1;
            exp0 = (i % 2 == 0);
            k = i / 2;
            check("rr_p0_gnt", bus.p0_gnt, exp0);
            check("rr_p1_gnt", bus.p1_gnt, !exp0);
            check("rr_mem_re", bus.mem_re, 1'b1);
            check("rr_mem_addr", bus.mem_addr, exp0 ? 4 * k : 28 - 4 * k);
            if (i > 0) begin
                k = (i - 1) / 2;
                check("rr_p0_rvalid", bus.p0_rvalid, !exp0);
                check("rr_p1_rvalid", bus.p1_rvalid, exp0);
                if (exp0) check("rr_p1_rdata", bus.p1_rdata, 32'hA000_0007 - k);
                else      check("rr_p0_rdata", bus.p0_rdata, 32'hA000_0000 + k);
            end
        end
        next();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        #1;
        check("rr_last_p1_rvalid", bus.p1_rvalid, 1'b1);
        check("rr_last_p0_rvalid", bus.p0_rvalid, 1'b0);
        check("rr_last_p1_rdata", bus.p1_rdata, 32'hA000_0005);
        check("rr_p0_rdata_hold", bus.p0_rdata, 32'hA000_0002);

        // Single p0 read so that p0 is the most recent grant before the lock
        next();
        bus.p0_req = 1'b1; bus.p0_addr = 32'd12;
        #1;
        check("solo_p0_gnt", bus.p0_gnt, 1'b1);

        // Lock: p1 wins four cycles in a row even though p0 is owed a turn
        for (int j = 0; j < 4; j++) begin
            next();
            bus.p0_addr = 32'd16;
            bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_addr = 32'd0;
            #1;
            check("lk_p1_gnt", bus.p1_gnt, 1'b1);
            check("lk_p0_gnt", bus.p0_gnt, 1'b0);
            if (j == 0) begin
                check("lk_p0_rvalid", bus.p0_rvalid, 1'b1);
                check("lk_p0_rdata", bus.p0_rdata, 32'hA000_0003);
            end else begin
                check("lk_p1_rvalid", bus.p1_rvalid, 1'b1);
                check("lk_p1_rdata", bus.p1_rdata, 32'hA000_0000);
            end
        end
        next();
        bus.p1_lock = 1'b0;
        #1;
        check("unlk_p0_gnt", bus.p0_gnt, 1'b1);
        check("unlk_p1_gnt", bus.p1_gnt, 1'b0);
        check("unlk_mem_addr", bus.mem_addr, 32'd16);

        // Lock without a port 1 request has no effect
        next();
        bus.p0_addr = 32'd20; bus.p1_req = 1'b0; bus.p1_lock = 1'b1;
        #1;
        check("lknr_p0_gnt", bus.p0_gnt, 1'b1);
        check("lknr_p0_rdata", bus.p0_rdata, 32'hA000_0004);

        // Cross reads: p1 at 8 (owed the turn), then p0 at 4
        next();
        bus.p1_lock = 1'b0;
        bus.p0_addr = 32'd4; bus.p1_req = 1'b1; bus.p1_addr = 32'd8;
        #1;
        check("x_p1_gnt", bus.p1_gnt, 1'b1);
        check("x_p0_gnt", bus.p0_gnt, 1'b0);
        check("x_p0_rdata_prev", bus.p0_rdata, 32'hA000_0005);
        next();
        bus.p1_req = 1'b0;
        #1;
        check("x_p0_gnt2", bus.p0_gnt, 1'b1);
        check("x_p1_rvalid", bus.p1_rvalid, 1'b1);
        check("x_p0_rvalid0", bus.p0_rvalid, 1'b0);
        check("x_p1_rdata", bus.p1_rdata, 32'hA000_0002);
        next();
        bus.p0_req = 1'b0;
        #1;
        check("x_p0_rvalid", bus.p0_rvalid, 1'b1);
        check("x_p1_rvalid0", bus.p1_rvalid, 1'b0);
        check("x_p0_rdata", bus.p0_rdata, 32'hA000_0001);
        check("x_p1_rdata_hold", bus.p1_rdata, 32'hA000_0002);

        // Reset the cycle after a p0 grant
        next();
        bus.p0_req = 1'b1; bus.p0_addr = 32'd8;
        #1;
        check("rf_p0_gnt", bus.p0_gnt, 1'b1);
        next();
        rst = 1'b1;
        #1;
        check("rf_rst_p0_gnt", bus.p0_gnt, 1'b0);
        check("rf_rst_booting", booting, 1'b1);
        next();
        rst = 1'b0; bus.p0_req = 1'b0;
        #1;
        check("rf_p0_rvalid", bus.p0_rvalid, 1'b0);
        check("rf_p1_rvalid", bus.p1_rvalid, 1'b0);
        check("rf_booting", booting, 1'b1);
        check("rf_mem_addr", bus.mem_addr, 32'h0);
        check("rf_mem_wdata", bus.mem_wdata, 32'h0);
        check("rf_p0_rdata", bus.p0_rdata, 32'h0);
        check("rf_p1_rdata", bus.p1_rdata, 32'h0);
        check("rf_mem_re", bus.mem_re, 1'b0);
        next();
        bus.p0_req = 1'b1;
        #1;
        check("rf_boot_p0_gnt", bus.p0_gnt, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates one single-port instruction/data memory (generic_mem, 1-cycle registered read) between two requesters: port 0 (instruction fetch, read-only) and port 1 (program loader / data access, read-write). After reset it runs a BOOT phase where only port 1 may access memory, so the loader fills the memory before fetch begins. It then switches to round-robin sharing with an optional burst lock for port 1. It sits between the program counter/fetch path, the loader, and the memory instance.

## Interface
- ADDR_W, 32, address width of both ports and memory
- DATA_W, 32, data width (one instruction word)

- clk  in  1  global clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- boot_done  in  1  loader finished; moves the arbiter BOOT -> RUN
- p0_req  in  1  fetch read request, held until granted
- p0_addr  in  ADDR_W  fetch address
- p0_gnt  out  1  fetch request accepted this cycle
- p0_rdata  out  DATA_W  fetch read data
- p0_rvalid  out  1  p0_rdata valid (one cycle)
- p1_req  in  1  loader/data request, held until granted
- p1_we  in  1  1 = write, 0 = read
- p1_lock  in  1  keep port 1 priority while asserted
- p1_addr  in  ADDR_W  port 1 address
- p1_wdata  in  DATA_W  port 1 write data
- p1_gnt  out  1  port 1 request accepted this cycle
- p1_rdata  out  DATA_W  port 1 read data
- p1_rvalid  out  1  p1_rdata valid (one cycle, reads only)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- booting  out  1  high in BOOT state (holds the PC latch off)

## Operation
- States: BOOT (reset state) and RUN.
- BOOT: p0_gnt is forced to 0. p1_req is granted every cycle it is high. A rising edge that samples boot_done=1 moves to RUN; a port 1 grant in that same cycle still completes. RUN never returns to BOOT except through rst.
- RUN arbitration is combinational within the cycle:
  - Only one port requesting: that port is granted.
  - Both requesting with p1_lock=1: port 1 is granted.
  - Both requesting otherwise: the port not granted most recently wins. The last-grant register resets to "port 1", so port 0 wins the first contention.
- The granted port drives mem_addr. mem_re = granted & read; mem_we = granted port 1 & p1_we. mem_wdata = p1_wdata. Port 0 never writes.
- With no grant, mem_re = mem_we = 0 and mem_addr/mem_wdata hold their last value.
- Read return:
  - A registered tag records which port issued the read.
  - Next cycle, the tagged port's rvalid pulses and its rdata = mem_rdata.
  - The other port's rdata keeps its previous value.
  - Writes produce no rvalid.
- Requesters must keep req and address/data stable until gnt; gnt is the only acceptance.
- When rst=1: p0_gnt = p1_gnt = 0, mem_re = mem_we = 0, and booting = 1, combinationally.

## Timing
- Values after reset: p0_gnt = p1_gnt = 0, p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0, mem_re = mem_we = 0, mem_addr = 0, mem_wdata = 0, booting = 1, state = BOOT.
- Grant latency: 0 cycles (gnt in the same cycle as req when the port wins).
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: 1 access per cycle total. Back-to-back reads from alternating ports give rvalid on consecutive cycles with no bubble.
- rst asserted with a read in flight: the pending rvalid is dropped (0 in the cycle after rst is sampled).
- boot_done held high for several cycles: same result as a single cycle.
- boot_done asserted during rst: ignored.
- p1_lock with p1_req=0: no effect; port 0 is granted if requesting.

## Test plan
- Reset, then p0_req=1 with boot_done=0 for 10 cycles -> p0_gnt stays 0, booting=1, mem_re=0.
- BOOT: port 1 writes 8 words 0xA0000000+n to addresses 0,4,...,28, then boot_done pulses -> mem_we on 8 consecutive cycles with matching addr/data, p1_rvalid never asserts, booting=0 the cycle after boot_done is sampled.
- RUN: p0 and p1 both request reads continuously -> grants alternate p0,p1,p0,… starting with p0; each rvalid is 1 cycle after its gnt and carries the correct memory word.
- RUN: p1_lock=1 with both ports requesting for 4 cycles -> p1 is granted all 4 cycles and p0 waits; when lock drops, p0 is granted next.
- Port 1 read at address 8 (data 0xA0000002) alongside a port 0 read at address 4 -> each rvalid goes to the correct port with data 0xA0000002 and 0xA0000001 respectively.
- rst asserted the cycle after a p0 grant -> p0_rvalid=0 the next cycle, state=BOOT, all outputs at their reset values.
